// File: rtl/hit_rate_monitor.sv
// rtl/hit_rate_monitor.sv - per-second hit counter with valid/ack publish, overrun flag and busy-run alarm
// Optional HIT_RATE_PEAK_EN builds a running peak of published rates on o_peak.
module hit_rate_monitor #(
   parameter int CNT_W  = 14,
   parameter int THRESH = 5000,
   parameter int CONSEC = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sec_pulse,
   input  logic             i_hit,
   input  logic             i_ack,
   output logic [CNT_W-1:0] o_rate,
   output logic             o_rate_valid,
   output logic             o_overrun,
   output logic             o_alarm,
   output logic [CNT_W-1:0] o_peak
);

   typedef enum logic {ALIGN, RUN} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);
   localparam logic [3:0]       CONSEC_V = 4'(CONSEC);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] rate_q, rate_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic [3:0]       run_q, run_d;
   logic             alarm_q, alarm_d;
   logic [CNT_W-1:0] result;
   logic             load;

   // Hit on the pulse cycle is folded into the closing window's result.
   assign result = (i_hit && (count_q != CNT_MAX)) ? count_q + 1'b1 : count_q;
   assign load   = (state_q == RUN) && i_sec_pulse;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rate_d    = rate_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      run_d     = run_q;
      alarm_d   = alarm_q;

      case (state_q)
         ALIGN: begin
            count_d = '0;
            if (i_sec_pulse) state_d = RUN;
         end
         RUN: begin
            count_d = i_sec_pulse ? '0 : result;
         end
         default: state_d = ALIGN;
      endcase

      if (valid_q && i_ack) valid_d = 1'b0;

      if (load) begin
         rate_d  = result;
         valid_d = 1'b1;
         if (valid_q && !i_ack) overrun_d = 1'b1;
         if (result >= THRESH_V)
            run_d = (run_q >= CONSEC_V) ? CONSEC_V : run_q + 4'd1;
         else
            run_d = 4'd0;
         alarm_d = (run_d == CONSEC_V);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ALIGN;
         count_q   <= '0;
         rate_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         run_q     <= 4'd0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rate_q    <= rate_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         run_q     <= run_d;
         alarm_q   <= alarm_d;
      end
   end

`ifdef HIT_RATE_PEAK_EN
   logic [CNT_W-1:0] peak_q, peak_d;

   always_comb begin
      peak_d = peak_q;
      if (load && (result > peak_q)) peak_d = result;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) peak_q <= '0;
      else       peak_q <= peak_d;
   end

   assign o_peak = peak_q;
`else
   assign o_peak = '0;
`endif

   assign o_rate       = rate_q;
   assign o_rate_valid = valid_q;
   assign o_overrun    = overrun_q;
   assign o_alarm      = alarm_q;

endmodule

// File: tb/tb_hit_rate_monitor.sv
// tb/tb_hit_rate_monitor.sv - randomized and directed bench for hit_rate_monitor against a behavioural model
module tb_hit_rate_monitor;

   localparam int CNT_W  = 14;
   localparam int THRESH = 5;
   localparam int CONSEC = 3;
   localparam int MAXV   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sec_pulse = 1'b0;
   logic             hit = 1'b0;
   logic             ack = 1'b0;
   logic [CNT_W-1:0] rate;
   logic             rate_valid;
   logic             overrun;
   logic             alarm;
   logic [CNT_W-1:0] peak;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // Reference state: plain integers describing what the outputs must be.
   bit m_aligned;
   int m_cnt, m_rate, m_valid, m_ovr, m_run, m_alarm, m_peak;

   hit_rate_monitor #(.CNT_W(CNT_W), .THRESH(THRESH), .CONSEC(CONSEC)) dut (
      .i_clk(clk), .i_rst(rst), .i_sec_pulse(sec_pulse), .i_hit(hit), .i_ack(ack),
      .o_rate(rate), .o_rate_valid(rate_valid), .o_overrun(overrun),
      .o_alarm(alarm), .o_peak(peak)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_aligned = 0; m_cnt = 0; m_rate = 0; m_valid = 0;
      m_ovr = 0; m_run = 0; m_alarm = 0; m_peak = 0;
   endtask

   task automatic model_step(input bit p, input bit h, input bit a);
      int total;
      if (!m_aligned) begin
         if (p) m_aligned = 1;
      end else begin
         total = m_cnt + h;
         if (total > MAXV) total = MAXV;
         if (p) begin
            if (m_valid && !a) m_ovr = 1;
            m_valid = 1;
            m_rate  = total;
            m_run   = (total >= THRESH) ? ((m_run + 1 > CONSEC) ? CONSEC : m_run + 1) : 0;
            m_alarm = (m_run == CONSEC);
`ifdef HIT_RATE_PEAK_EN
            if (total > m_peak) m_peak = total;
`endif
            m_cnt = 0;
         end else begin
            if (m_valid && a) m_valid = 0;
            m_cnt = total;
         end
      end
   endtask

   task automatic step(input bit p, input bit h, input bit a);
      @(negedge clk);
      sec_pulse = p; hit = h; ack = a;
      @(posedge clk);
      #1;
      model_step(p, h, a);
   endtask

   task automatic hits(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      sec_pulse = 1'b0; hit = 1'b0; ack = 1'b0;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("rate", int'(rate), m_rate);
         chk("rate_valid", int'(rate_valid), m_valid);
         chk("overrun", int'(overrun), m_ovr);
         chk("alarm", int'(alarm), m_alarm);
         chk("peak", int'(peak), m_peak);
      end
   end

   initial begin
      int exp_peak;
      int win[6];
      model_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;

      chk("reset_rate", int'(rate), 0);
      chk("reset_valid", int'(rate_valid), 0);
      chk("reset_peak", int'(peak), 0);

      // 30 hits before alignment are ignored; first pulse publishes nothing.
      hits(30);
      step(1'b1, 1'b0, 1'b0);
      chk("align_no_publish", int'(rate_valid), 0);
      hits(100);
      step(1'b1, 1'b0, 1'b0);
      chk("first_rate", int'(rate), 100);
      chk("first_valid", int'(rate_valid), 1);

      // Hit on the pulse cycle closes the window; ack on load avoids overrun.
      hits(9);
      step(1'b1, 1'b1, 1'b1);
      chk("pulse_hit_rate", int'(rate), 10);
      chk("ack_on_load_ovr", int'(overrun), 0);
      step(1'b1, 1'b0, 1'b1);
      chk("next_window_zero", int'(rate), 0);
      step(1'b0, 1'b0, 1'b1);
      chk("ack_clears_valid", int'(rate_valid), 0);

      // Busy-run alarm: 6,6,4,6,6,6 with THRESH=5 CONSEC=3.
      win = '{6, 6, 4, 6, 6, 6};
      for (int w = 0; w < 6; w++) begin
         hits(win[w]);
         step(1'b1, 1'b0, 1'b1);
         chk("alarm_seq", int'(alarm), (w == 5) ? 1 : 0);
      end

      // Peak over 40, 90, 10 after a fresh reset.
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      win[0] = 40; win[1] = 90; win[2] = 10;
      for (int w = 0; w < 3; w++) begin
         hits(win[w]);
         step(1'b1, 1'b0, 1'b1);
      end
`ifdef HIT_RATE_PEAK_EN
      exp_peak = 90;
`else
      exp_peak = 0;
`endif
      chk("peak_value", int'(peak), exp_peak);
      chk("peak_last_rate", int'(rate), 10);

      // Two unacked windows of 7 then 12 -> overrun.
      step(1'b0, 1'b0, 1'b1);
      hits(7);
      step(1'b1, 1'b0, 1'b0);
      hits(12);
      step(1'b1, 1'b0, 1'b0);
      chk("ovr_rate", int'(rate), 12);
      chk("ovr_valid", int'(rate_valid), 1);
      chk("ovr_flag", int'(overrun), 1);

      // Saturation.
      hits(20000);
      step(1'b1, 1'b1, 1'b1);
      chk("saturate", int'(rate), MAXV);

      // Async reset mid-window: everything clears and alignment is required again.
      hits(25);
      do_reset();
      chk("rst_rate", int'(rate), 0);
      chk("rst_valid", int'(rate_valid), 0);
      chk("rst_ovr", int'(overrun), 0);
      chk("rst_alarm", int'(alarm), 0);
      hits(5);
      step(1'b1, 1'b0, 1'b0);
      chk("rst_realign", int'(rate_valid), 0);

      // Randomized traffic including back-to-back pulses.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0));
      end
      for (int i = 0; i < 200; i++) begin
         step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hit_rate_monitor.md
# hit_rate_monitor

Counts single-cycle hit strobes (Tx or Rx events) over windows delimited by the 1-second pulse from the one-second timer. At each window boundary it publishes the per-second hit count with a valid/ack handshake. It also raises a threshold alarm after a configurable run of busy windows. It sits directly downstream of the timer and feeds the status/display logic.

## Interface
- CNT_W, 14: width of window counter and published rate (10 kHz clock → max 10000 hits/s fits).
- THRESH, 5000: alarm threshold; a window is "busy" when its rate ≥ THRESH.
- CONSEC, 3: number of consecutive busy windows required to assert alarm (1..15).

- i_clk  in  1  system clock (10 kHz domain shared with timer).
- i_rst  in  1  reset, asynchronous, active-high.
- i_sec_pulse  in  1  one-cycle window-boundary strobe from timer.
- i_hit  in  1  one-cycle hit strobe; may be high on consecutive cycles.
- i_ack  in  1  consumer acknowledge of published rate.
- o_rate  out  CNT_W  hit count of last completed window.
- o_rate_valid  out  1  o_rate holds an unacknowledged result.
- o_overrun  out  1  sticky: a result was overwritten before ack.
- o_alarm  out  1  CONSEC consecutive busy windows seen.
- o_peak  out  CNT_W  largest o_rate since reset (see Configuration).

## Operation
- Reset values: o_rate=0, o_rate_valid=0, o_overrun=0, o_alarm=0, o_peak=0, window count=0, busy-run count=0, state=ALIGN.
- States: ALIGN → RUN only. Not a free-running counter before alignment.
- ALIGN: hits ignored, window count held at 0. First i_sec_pulse moves to RUN; no result published for that pulse.
- RUN, no pulse: i_hit increments window count by 1, saturating at 2^CNT_W−1.
- RUN, pulse: window result = count plus 1 if i_hit is high that same cycle (saturating). Result loads into o_rate. Window count restarts at 0; a hit on the pulse cycle belongs to the closing window.
- Handshake: o_rate_valid set on load. Cleared the cycle after i_ack sampled high while valid. i_ack with valid low is ignored.
- Load while valid high and no i_ack that cycle: o_rate overwritten, valid stays 1, o_overrun set (cleared only by reset).
- Load and i_ack in same cycle: new result loaded, valid stays 1, no overrun.
- Alarm: on each load, if result ≥ THRESH, busy-run count increments (saturating at CONSEC); otherwise it clears to 0. o_alarm = (busy-run count == CONSEC), updated together with o_rate.
- Asynchronous reset mid-window discards the partial count and returns to ALIGN.

## Timing
- All outputs registered. o_rate, o_rate_valid, o_alarm and o_peak change on the clock edge that samples i_sec_pulse high.
- Latency from the pulse-sampling edge to outputs is 0 cycles; the values are visible in the cycle following the pulse.
- Valid falls on the edge that samples i_ack high, so the consumer sees one cycle of valid&ack.
- Back-to-back pulses (window length 1): each is a legal window of 0 or 1 hits.

## Configuration
- HIT_RATE_PEAK_EN defined: o_peak updates on each load to max(o_peak, result). The update is registered with o_rate.
- HIT_RATE_PEAK_EN undefined: peak register and comparator are not built; o_peak is tied to 0. All other behaviour is identical.

## Test plan
- Reset, 30 hits, pulse, 100 hits, pulse → first pulse publishes nothing; second gives o_rate=100, o_rate_valid=1.
- Hit asserted on the pulse cycle plus 9 hits before it → o_rate=10; the next window starts at 0.
- Two windows of 7 then 12 hits with no ack → o_rate=12, valid=1, o_overrun=1. Ack on the load cycle instead → o_overrun stays 0.
- i_hit held high for 20000 cycles, then pulse, with CNT_W=14 → o_rate=16383.
- THRESH=5, CONSEC=3; windows of 6,6,4,6,6,6 hits → o_alarm low, low, low, low, low, then high on the 6th load.
- With HIT_RATE_PEAK_EN: windows 40, 90, 10 → o_peak=90. Without the macro → o_peak=0 throughout. Async reset mid-window → all outputs 0, state ALIGN.
